// File: rtl/dds_par_xfer.sv
// DDS parallel-port transfer engine: queued read/write words serialised MSB-slot first on a free-running PCLK.
// Optional IO_UPDATE slot after writes is enabled by defining DDS_XFER_IOUP_EN.
module dds_par_xfer #(
    parameter int DATA_W    = 8,
    parameter int BYTES     = 4,
    parameter int HALF_PER  = 2,
    parameter int CMD_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_wr,
    input  logic [DATA_W*BYTES-1:0]  cmd_data,
    input  logic                     flush,
    output logic                     busy,
    output logic                     done,
    output logic                     rsp_valid,
    output logic [DATA_W*BYTES-1:0]  rsp_data,
    output logic                     DDS_PCLK,
    output logic                     DDS_IOup,
    output logic                     DDS_CSn,
    output logic                     DDS_RWn,
    output logic                     DDS_ReadEn,
    output logic [DATA_W-1:0]        DDS_DataOut,
    input  logic [DATA_W-1:0]        DDS_DataIn
);

    localparam int WORD_W = DATA_W * BYTES;
    localparam int PC_N   = 2 * HALF_PER;
    localparam int PC_W   = $clog2(PC_N);
    localparam int AW     = $clog2(CMD_DEPTH);
    localparam int K_W    = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [PC_W-1:0] PC_MAX = PC_W'(PC_N - 1);
    localparam logic [PC_W-1:0] PC_PRE = PC_W'(PC_N - 2);
    localparam logic [PC_W-1:0] PC_HI  = PC_W'(HALF_PER);
    localparam logic [K_W-1:0]  K_LAST = K_W'(BYTES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DATA = 2'd1;
    localparam logic [1:0] S_IOUP = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   pc_n;
    logic              slot_end;
    logic [1:0]        state;
    logic [1:0]        state_n;
    logic [K_W-1:0]    k;
    logic [K_W-1:0]    k_n;

    logic [WORD_W:0]   mem [CMD_DEPTH];
    logic [AW:0]       wp;
    logic [AW:0]       rp;
    logic              empty;
    logic              full;
    logic              push;
    logic              pop;
    logic [WORD_W:0]   head;

    logic              cur_wr;
    logic [WORD_W-1:0] cur_data;
    logic              word_wr;
    logic [WORD_W-1:0] word_dat;
    logic [DATA_W-1:0] byte_n;
    logic [WORD_W-1:0] shadow;
    logic              fin;

    assign slot_end = (pc == PC_MAX);
    assign pc_n     = slot_end ? '0 : pc + 1'b1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc       <= '0;
            DDS_PCLK <= 1'b0;
        end else begin
            pc       <= pc_n;
            DDS_PCLK <= (pc_n >= PC_HI);
        end
    end

    assign empty     = (wp == rp);
    assign full      = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full && !flush;
    assign head      = mem[rp[AW-1:0]];
    assign pop       = slot_end && !empty && !flush &&
                       ((state == S_IDLE) || (state == S_GAP));
    assign busy      = (state != S_IDLE) || !empty;

    always_ff @(posedge clk) begin
        if (push)
            mem[wp[AW-1:0]] <= {cmd_wr, cmd_data};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push)
                wp <= wp + 1'b1;
            if (flush)
                rp <= wp;
            else if (pop)
                rp <= rp + 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        k_n     = k;
        unique case (state)
            S_IDLE: begin
                if (pop) begin
                    state_n = S_DATA;
                    k_n     = '0;
                end
            end
            S_DATA: begin
                if (slot_end) begin
                    if (k == K_LAST) begin
`ifdef DDS_XFER_IOUP_EN
                        state_n = cur_wr ? S_IOUP : S_GAP;
`else
                        state_n = S_GAP;
`endif
                    end else begin
                        k_n = k + 1'b1;
                    end
                end
            end
            S_IOUP: begin
                if (slot_end)
                    state_n = S_GAP;
            end
            S_GAP: begin
                if (slot_end) begin
                    state_n = pop ? S_DATA : S_IDLE;
                    k_n     = '0;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // The popped word drives slot 0 on the same edge it is latched
    assign word_wr  = pop ? head[WORD_W] : cur_wr;
    assign word_dat = pop ? head[WORD_W-1:0] : cur_data;

    always_comb begin
        byte_n = word_dat[WORD_W-1 - int'(k_n)*DATA_W -: DATA_W];
    end

    assign fin = (state == S_GAP) && (pc == PC_PRE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= S_IDLE;
            k           <= '0;
            cur_wr      <= 1'b0;
            cur_data    <= '0;
            DDS_CSn     <= 1'b1;
            DDS_RWn     <= 1'b1;
            DDS_ReadEn  <= 1'b0;
            DDS_DataOut <= '0;
            shadow      <= '0;
            done        <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
        end else begin
            state      <= state_n;
            k          <= k_n;
            DDS_CSn    <= (state_n != S_DATA);
            DDS_ReadEn <= (state_n == S_DATA) && !word_wr;
            if ((state_n == S_DATA) && word_wr)
                DDS_DataOut <= byte_n;
            else
                DDS_DataOut <= '0;
            if (pop) begin
                cur_wr   <= head[WORD_W];
                cur_data <= head[WORD_W-1:0];
                DDS_RWn  <= !head[WORD_W];
            end else if (state_n == S_IDLE) begin
                DDS_RWn  <= 1'b1;
            end
            if ((state == S_DATA) && slot_end && !cur_wr)
                shadow[WORD_W-1 - int'(k)*DATA_W -: DATA_W] <= DDS_DataIn;
            done      <= fin;
            rsp_valid <= fin && !cur_wr;
            if (fin && !cur_wr)
                rsp_data <= shadow;
        end
    end

`ifdef DDS_XFER_IOUP_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            DDS_IOup <= 1'b0;
        else
            DDS_IOup <= (state_n == S_IOUP);
    end
`else
    assign DDS_IOup = 1'b0;
`endif

endmodule

// File: tb/tb_dds_par_xfer.sv
// Directed bench for dds_par_xfer (defaults: 8-bit bus, 4 slots/word, 4-clk slot, 4-deep FIFO).
// Expectations adapt to whether DDS_XFER_IOUP_EN is defined.
module tb_dds_par_xfer;

`ifdef DDS_XFER_IOUP_EN
    localparam int WR_LAT = 24;
    localparam int GAP_EX = 8;
    localparam int IO_EX  = 4;
`else
    localparam int WR_LAT = 20;
    localparam int GAP_EX = 4;
    localparam int IO_EX  = 0;
`endif

    logic        clk = 0;
    logic        rstn = 0;
    logic        cmd_valid = 0;
    logic        cmd_ready;
    logic        cmd_wr = 0;
    logic [31:0] cmd_data = 0;
    logic        flush = 0;
    logic        busy;
    logic        done;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        pclk;
    logic        ioup;
    logic        csn;
    logic        rwn;
    logic        read_en;
    logic [7:0]  dout;
    logic [7:0]  din = 0;

    dds_par_xfer dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_wr(cmd_wr), .cmd_data(cmd_data), .flush(flush),
        .busy(busy), .done(done),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .DDS_PCLK(pclk), .DDS_IOup(ioup), .DDS_CSn(csn),
        .DDS_RWn(rwn), .DDS_ReadEn(read_en),
        .DDS_DataOut(dout), .DDS_DataIn(din)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nfail = 0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]  rd_bytes [4] = '{8'hAB, 8'hCD, 8'hEF, 8'h01};
    int          lowcnt = 0;
    int          highcnt = 0;
    int          last_run = 0;
    int          runs = 0;
    int          low_start = 0;
    int          done_lat = 0;
    int          done_cnt = 0;
    int          rsp_cnt = 0;
    int          rsp_done = 0;
    int          re_cyc = 0;
    int          io_cyc = 0;
    int          dout_nz = 0;
    bit          seen = 0;
    logic [31:0] cap = 0;
    logic [31:0] wq [$];
    int          gap_q [$];

    // Bus monitor: rebuilds written words, drives read bytes, counts strobes
    always @(negedge clk) begin
        if (!csn) begin
            if (lowcnt == 0) begin
                runs = runs + 1;
                low_start = cyc;
                if (seen)
                    gap_q.push_back(highcnt);
                seen = 1;
            end
            lowcnt = lowcnt + 1;
            highcnt = 0;
            if (!rwn && ((lowcnt - 1) % 4) == 0)
                cap = {cap[23:0], dout};
            if (rwn && dout != 8'h00)
                dout_nz = dout_nz + 1;
            if (lowcnt == 16 && !rwn)
                wq.push_back(cap);
            if (lowcnt <= 16)
                din <= rd_bytes[(lowcnt - 1) / 4];
        end else begin
            if (lowcnt != 0)
                last_run = lowcnt;
            lowcnt = 0;
            highcnt = highcnt + 1;
        end
        if (read_en)
            re_cyc = re_cyc + 1;
        if (ioup)
            io_cyc = io_cyc + 1;
        if (done) begin
            done_cnt = done_cnt + 1;
            done_lat = cyc - low_start + 1;
        end
        if (rsp_valid) begin
            rsp_cnt = rsp_cnt + 1;
            if (done)
                rsp_done = rsp_done + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic wr, input logic [31:0] d);
        int t;
        cmd_valid = 1;
        cmd_wr = wr;
        cmd_data = d;
        t = 0;
        while (!cmd_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("push_ready", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 0;
    endtask

    task automatic wait_csn_low();
        int t;
        t = 0;
        while (csn && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("csn_low_timeout", csn, 0);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk("idle_timeout", busy, 0);
    endtask

    int d0, r0, i0, e0, n0, g0, w0;

    initial begin
        repeat (3) @(negedge clk);
        // reset state
        chk("rst_csn", csn, 1);
        chk("rst_rwn", rwn, 1);
        chk("rst_readen", read_en, 0);
        chk("rst_ioup", ioup, 0);
        chk("rst_dout", dout, 0);
        chk("rst_pclk", pclk, 0);
        chk("rst_done", done, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", cmd_ready, 1);
        rstn = 1;
        repeat (3) @(negedge clk);

        // 1: single write
        d0 = done_cnt; i0 = io_cyc; w0 = wq.size();
        push(1, 32'h12345678);
        chk("t1_busy", busy, 1);
        wait_csn_low();
        chk("t1_rwn", rwn, 0);
        chk("t1_readen", read_en, 0);
        chk("t1_dout0", dout, 8'h12);
        wait_idle();
        chk("t1_run", last_run, 16);
        chk("t1_word", wq.size() > w0 ? wq[$] : 32'hx, 32'h12345678);
        chk("t1_done_cnt", done_cnt - d0, 1);
        chk("t1_done_lat", done_lat, WR_LAT);
        chk("t1_ioup", io_cyc - i0, IO_EX);
        chk("t1_rwn_idle", rwn, 1);

        // 2: single read
        d0 = done_cnt; r0 = rsp_cnt; e0 = re_cyc; i0 = io_cyc; n0 = dout_nz;
        push(0, 32'hFFFFFFFF);
        wait_csn_low();
        chk("t2_rwn", rwn, 1);
        chk("t2_readen", read_en, 1);
        wait_idle();
        chk("t2_readen_cyc", re_cyc - e0, 16);
        chk("t2_rsp_cnt", rsp_cnt - r0, 1);
        chk("t2_rsp_with_done", rsp_done, 1);
        chk("t2_done_cnt", done_cnt - d0, 1);
        chk("t2_done_lat", done_lat, 20);
        chk("t2_rsp_data", rsp_data, 32'hABCDEF01);
        chk("t2_ioup", io_cyc - i0, 0);
        chk("t2_dout_zero", dout_nz - n0, 0);

        // 3: three back-to-back writes
        d0 = done_cnt; g0 = gap_q.size(); w0 = wq.size();
        push(1, 32'hA1A2A3A4);
        push(1, 32'hB1B2B3B4);
        push(1, 32'hC1C2C3C4);
        wait_idle();
        chk("t3_done_cnt", done_cnt - d0, 3);
        chk("t3_gap_n", gap_q.size() - g0, 3);
        chk("t3_gap1", gap_q.size() > g0 + 1 ? gap_q[g0 + 1] : -1, GAP_EX);
        chk("t3_gap2", gap_q.size() > g0 + 2 ? gap_q[g0 + 2] : -1, GAP_EX);
        chk("t3_words", wq.size() - w0, 3);
        chk("t3_w0", wq.size() > w0 ? wq[w0] : 32'hx, 32'hA1A2A3A4);
        chk("t3_w2", wq.size() > w0 + 2 ? wq[w0 + 2] : 32'hx, 32'hC1C2C3C4);
        chk("t3_busy", busy, 0);

        // 4: fill FIFO while busy, sixth offer refused
        d0 = done_cnt; w0 = wq.size();
        push(1, 32'h0A0A0A0A);
        wait_csn_low();
        push(1, 32'h0B0B0B0B);
        push(1, 32'h0C0C0C0C);
        push(1, 32'h0D0D0D0D);
        chk("t4_ready_3q", cmd_ready, 1);
        push(1, 32'h0E0E0E0E);
        chk("t4_ready_full", cmd_ready, 0);
        cmd_valid = 1; cmd_wr = 1; cmd_data = 32'h0F0F0F0F;
        repeat (3) @(negedge clk);
        chk("t4_ready_held", cmd_ready, 0);
        cmd_valid = 0;
        begin
            int t;
            t = 0;
            while (!cmd_ready && t < 200) begin
                @(negedge clk);
                t++;
            end
        end
        chk("t4_ready_back", cmd_ready, 1);
        chk("t4_first_done", done_cnt - d0, 1);
        wait_idle();
        chk("t4_done_cnt", done_cnt - d0, 5);
        chk("t4_words", wq.size() - w0, 5);
        chk("t4_wA", wq.size() > w0 ? wq[w0] : 32'hx, 32'h0A0A0A0A);
        chk("t4_wC", wq.size() > w0 + 2 ? wq[w0 + 2] : 32'hx, 32'h0C0C0C0C);
        chk("t4_wE", wq.size() > w0 + 4 ? wq[w0 + 4] : 32'hx, 32'h0E0E0E0E);

        // 5: reset during read slot 2
        d0 = done_cnt; r0 = rsp_cnt;
        push(0, 32'h0);
        push(1, 32'h55555555);
        wait_csn_low();
        repeat (8) @(negedge clk);
        chk("t5_in_slot2", read_en, 1);
        rstn = 0;
        @(negedge clk);
        chk("t5_csn", csn, 1);
        chk("t5_readen", read_en, 0);
        chk("t5_busy", busy, 0);
        chk("t5_rsp_data", rsp_data, 0);
        rstn = 1;
        repeat (10) @(negedge clk);
        chk("t5_no_rsp", rsp_cnt - r0, 0);
        chk("t5_no_done", done_cnt - d0, 0);
        chk("t5_queue_lost", busy, 0);
        n0 = runs;
        push(1, 32'hCAFEF00D);
        wait_idle();
        chk("t5_restart_word", wq[$], 32'hCAFEF00D);
        chk("t5_restart_runs", runs - n0, 1);
        chk("t5_restart_done", done_cnt - d0, 1);

        // 6: flush while three are queued
        d0 = done_cnt; n0 = runs; i0 = io_cyc; w0 = wq.size();
        push(1, 32'h11111111);
        wait_csn_low();
        push(1, 32'h22222222);
        push(1, 32'h33333333);
        push(1, 32'h44444444);
        flush = 1;
        @(negedge clk);
        flush = 0;
        chk("t6_inflight", busy, 1);
        wait_idle();
        repeat (12) @(negedge clk);
        chk("t6_done_cnt", done_cnt - d0, 1);
        chk("t6_runs", runs - n0, 1);
        chk("t6_word", wq.size() > w0 ? wq[w0] : 32'hx, 32'h11111111);
        chk("t6_ioup", io_cyc - i0, IO_EX);

        // flush and push in the same cycle: push dropped
        d0 = done_cnt;
        cmd_valid = 1; cmd_wr = 1; cmd_data = 32'h99999999; flush = 1;
        @(negedge clk);
        cmd_valid = 0; flush = 0;
        chk("t7_dropped", busy, 0);
        repeat (30) @(negedge clk);
        chk("t7_no_done", done_cnt - d0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
